// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder behind the MEM-stage SRAM request port.
// Accepts a word read or a byte-lane write and holds ram_busy_o for WAIT_CYCLES
// wait states. On the commit edge it updates the array or samples the read word.
// It then spends one RESP cycle, where a read raises ram_read_valid_o.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ram_read_enable_i   read request, held while busy
//   ram_read_addr_i     byte address of read (bits [1:0] ignored)
//   ram_write_enable_i  write request, held while busy (wins over read)
//   ram_write_select_i  byte-lane enables for the write
//   ram_write_addr_i    byte address of write (bits [1:0] ignored)
//   ram_write_data_i    lane-replicated write data
//   ram_read_data_o     registered read data, held until the next read commit
//   ram_read_valid_o    one-cycle pulse in RESP for reads
//   ram_busy_o          combinational stall request to the pipeline
//   err_o               protocol error pulse in RESP
//
// Optional feature: define DMEM_ERR_CHECK_EN to flag simultaneous read+write and
// out-of-range addresses on err_o. Without it, err_o is tied low.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_read_enable_i,
  input  logic [31:0] ram_read_addr_i,
  input  logic        ram_write_enable_i,
  input  logic [3:0]  ram_write_select_i,
  input  logic [31:0] ram_write_addr_i,
  input  logic [31:0] ram_write_data_i,
  output logic [31:0] ram_read_data_o,
  output logic        ram_read_valid_o,
  output logic        ram_busy_o,
  output logic        err_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state, next_state;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    accept;

  logic                    lat_wr;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [3:0]              lat_sel;
  logic [31:0]             lat_data;

  logic                    req;
  logic [31:0]             req_addr;
  logic                    cur_wr;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic [3:0]              cur_sel;
  logic [31:0]             cur_data;
  logic                    commit;

  logic [31:0]             mem [0:DEPTH-1];

  // Request decode: a write takes priority over a simultaneous read.
  assign req      = ram_read_enable_i | ram_write_enable_i;
  assign req_addr = ram_write_enable_i ? ram_write_addr_i : ram_read_addr_i;

  // With zero wait states, commit happens on the accepting edge, so use live inputs.
  assign cur_wr   = (state == S_IDLE) ? ram_write_enable_i : lat_wr;
  assign cur_idx  = (state == S_IDLE) ? req_addr[ADDR_WIDTH+1:2] : lat_idx;
  assign cur_sel  = (state == S_IDLE) ? ram_write_select_i : lat_sel;
  assign cur_data = (state == S_IDLE) ? ram_write_data_i : lat_data;

  // Next-state, counter and stall logic.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    ram_busy_o = 1'b0;
    case (state)
      S_IDLE: begin
        ram_busy_o = req;
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = S_RESP;
          end else begin
            next_state = S_WAIT;
            cnt_next   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        ram_busy_o = 1'b1;
        if (cnt == '0) next_state = S_RESP;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (rst) ram_busy_o = 1'b0;
  end

  assign commit = (next_state == S_RESP);

  // State, request latch and registered read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      lat_wr           <= 1'b0;
      lat_idx          <= '0;
      lat_sel          <= '0;
      lat_data         <= '0;
      ram_read_data_o  <= '0;
      ram_read_valid_o <= 1'b0;
    end else begin
      state            <= next_state;
      cnt              <= cnt_next;
      ram_read_valid_o <= commit & ~cur_wr;
      if (accept) begin
        lat_wr   <= ram_write_enable_i;
        lat_idx  <= req_addr[ADDR_WIDTH+1:2];
        lat_sel  <= ram_write_select_i;
        lat_data <= ram_write_data_i;
      end
      if (commit && !cur_wr) ram_read_data_o <= mem[cur_idx];
    end
  end

  // Byte-lane array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && commit && cur_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_sel[i]) mem[cur_idx][8*i +: 8] <= cur_data[8*i +: 8];
      end
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  logic lat_err;
  logic cur_err;
  logic unused_addr;

  // Error is judged at acceptance and reported in the RESP cycle.
  assign cur_err = (state == S_IDLE)
                 ? ((ram_read_enable_i & ram_write_enable_i) | (|req_addr[31:ADDR_WIDTH+2]))
                 : lat_err;
  assign unused_addr = ^req_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_err <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      if (accept) lat_err <= cur_err;
      err_o <= commit & cur_err;
    end
  end
`else
  logic unused_addr;

  assign unused_addr = ^{req_addr[1:0], req_addr[31:ADDR_WIDTH+2]};
  assign err_o       = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the MEM-stage SRAM request interface.
- Accepts word-aligned read or byte-lane write requests from the pipeline's memory stage and stores data in an internal word array.
- Stalls the pipeline for a configurable number of wait states, then returns read data.
- Provides the sequential, latency-bearing memory the MEM stage issues requests against, for simulation and for FPGA block RAM inference.

Parameters:
- ADDR_WIDTH, 12, word-index bits; array depth 2^ADDR_WIDTH words (16 KB at default).
- WAIT_CYCLES, 1, wait states between request acceptance and response (0..15).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ram_read_enable_i  input  1  read request, held stable while ram_busy_o=1.
- ram_read_addr_i  input  32  byte address; bits [1:0] ignored.
- ram_write_enable_i  input  1  write request, held stable while ram_busy_o=1.
- ram_write_select_i  input  4  byte lanes; bit n writes data[8n+7:8n].
- ram_write_addr_i  input  32  byte address; bits [1:0] ignored.
- ram_write_data_i  input  32  lane-replicated write data.
- ram_read_data_o  output  32  read data, registered.
- ram_read_valid_o  output  1  one-cycle pulse, read data valid.
- ram_busy_o  output  1  stall request to pipeline.
- err_o  output  1  protocol error pulse (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE; counter=0; ram_read_data_o=0; ram_read_valid_o=0; err_o=0.
  - ram_busy_o=0 while rst=1.
  - Array contents are not reset.
- Word index = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so the array aliases / wraps around.
- States: IDLE, WAIT, RESP.
- IDLE:
  - ram_busy_o = ram_read_enable_i | ram_write_enable_i (combinational).
  - On a request, latch kind, word index, select and data.
  - WAIT_CYCLES=0: go to RESP. Otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - ram_busy_o=1.
  - If counter=0, go to RESP; else decrement the counter.
- Commit edge (the edge entering RESP):
  - Write: each lane with select=1 is updated from the latched data. Select 4'b0000 is a no-op but completes the handshake normally.
  - Read: the latched word is sampled into ram_read_data_o.
- RESP:
  - ram_busy_o=0.
  - ram_read_valid_o=1 for exactly this cycle (reads only).
  - Always returns to IDLE next edge. The still-asserted request in RESP belongs to the completed access and is NOT re-accepted.
- Latency: request first seen in IDLE at cycle 0 → response in cycle 1+WAIT_CYCLES. Back-to-back accesses cost 2+WAIT_CYCLES cycles each.
- ram_read_data_o holds its value until the next read commit; it is unchanged by writes.
- Read after write to the same word returns post-write data; no bypass is needed because the write commits before the next acceptance.
- Simultaneous ram_read_enable_i and ram_write_enable_i in IDLE:
  - Treated as a write only.
  - No ram_read_valid_o pulse.
- Request dropped while busy is illegal; the latched request completes regardless.
- Reset mid-operation (in WAIT or IDLE-accept) aborts the access; an uncommitted write leaves the array unchanged.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined: err_o pulses for one cycle (the RESP cycle of the offending access) when either condition holds at acceptance:
  - read and write were requested simultaneously;
  - the address bits above ADDR_WIDTH+1 are nonzero (out of range).
- The access still proceeds as specified above.
- Undefined: err_o is tied to 0 and no checking logic is present; data behaviour is identical.

Test Plan:
- WAIT_CYCLES=1: write 0xDEADBEEF with select 4'b1111 to 0x00000010, then read 0x00000010 → busy high for 2 cycles per access; read_valid pulses in cycle 2 of the read with data 0xDEADBEEF.
- Byte lanes: word 0x40 preloaded 0x11223344; write 0xAAAAAAAA with select 4'b0100; read 0x42 → 0x11AA3344.
- WAIT_CYCLES=0: read, read, write, read at addresses 0x0/0x4/0x8/0x8 → each response 1 cycle after acceptance, never double-accepted; final read returns the written data.
- Simultaneous read+write of 0x55 to 0x20 with select 4'b0001 → byte written, no read_valid pulse, err_o=1 in RESP (macro defined) / err_o=0 (undefined).
- Reset asserted in WAIT during a write of 0xFFFFFFFF to 0x30 (old 0x12345678) → outputs zero immediately, state IDLE; a subsequent read of 0x30 returns 0x12345678.
- ADDR_WIDTH=12: write to 0x00004004 → aliases to word 1; read of 0x4 returns that data; err_o=1 with the macro defined.
